// File: rtl/lcd_line_buffer_if.sv
// Producer-side pixel stream into the LCD line buffer: RGB565 data, valid/ready, end-of-line marker.
interface lcd_line_buffer_if;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] IN_DATA;
  logic        IN_LAST;

  modport master (output IN_VALID, IN_DATA, IN_LAST, input IN_READY);
  modport slave  (input IN_VALID, IN_DATA, IN_LAST, output IN_READY);
endinterface

// File: rtl/lcd_line_buffer.sv
// Ping-pong RGB565 line buffer feeding the LCD pixel stage; replays one stored line per DE window.
// Optional build macro LCD_LB_STATS_EN adds the saturating UNDERFLOW_CNT output.
module lcd_line_buffer #(
  parameter int LINE_PIXELS = 800,
  parameter int ADDR_W      = 10
) (
  input  logic             PixelClk,
  input  logic             RST,
  lcd_line_buffer_if.slave pix,
  input  logic             DE_IN,
  input  logic             HS_IN,
  input  logic             VS_IN,
  output logic             LCD_DE,
  output logic             LCD_HSYNC,
  output logic             LCD_VSYNC,
  output logic [4:0]       LCD_R,
  output logic [5:0]       LCD_G,
  output logic [4:0]       LCD_B,
  output logic             UNDERFLOW
`ifdef LCD_LB_STATS_EN
  ,
  output logic [15:0]      UNDERFLOW_CNT
`endif
);

  typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_READING} bank_state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(LINE_PIXELS - 1);
  localparam logic [ADDR_W:0]   LINE_LEN = (ADDR_W + 1)'(LINE_PIXELS);

  bank_state_t       bank_st [2];
  bank_state_t       st_n    [2];
  logic [ADDR_W:0]   len     [2];
  logic [ADDR_W:0]   len_n   [2];
  logic              wr_sel, wr_sel_n;
  logic              rd_sel, rd_sel_n;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_n;
  logic [ADDR_W:0]   rd_ptr, rd_ptr_n;
  logic              discard, discard_n;
  logic              de_q, vs_q;
  logic              de_rise, de_fall, vs_fall;
  logic              xfer, reading_now, pix_ok, underflow_n;
  logic              de_d1, hs_d1, vs_d1, pix_ok_q;
  logic [15:0]       rd_data;
  logic [15:0]       mem [2**(ADDR_W + 1)];

  assign de_rise = DE_IN && !de_q;
  assign de_fall = !DE_IN && de_q;
  assign vs_fall = !VS_IN && vs_q;

  assign pix.IN_READY = !RST && (discard || bank_st[wr_sel] == B_FREE
                                         || bank_st[wr_sel] == B_FILLING);
  assign xfer = pix.IN_VALID && pix.IN_READY;

  // The bank is judged on its registered state, so a line closing on the DE rise edge waits.
  assign reading_now = !vs_fall && (de_rise ? (bank_st[rd_sel] == B_FULL)
                                            : (DE_IN && bank_st[rd_sel] == B_READING));
  assign pix_ok = reading_now && (rd_ptr < len[rd_sel]) && (rd_ptr < LINE_LEN);

  always_comb begin
    // NOTE: every next-state variable takes its current value first, so no latch is inferred.
    st_n        = bank_st;
    len_n       = len;
    wr_sel_n    = wr_sel;
    rd_sel_n    = rd_sel;
    wr_ptr_n    = wr_ptr;
    rd_ptr_n    = rd_ptr;
    discard_n   = discard;
    underflow_n = 1'b0;

    if (xfer) begin
      if (discard) begin
        if (pix.IN_LAST) discard_n = 1'b0;
      end else if (pix.IN_LAST || wr_ptr == LAST_PTR) begin
        st_n[wr_sel]  = B_FULL;
        len_n[wr_sel] = {1'b0, wr_ptr} + 1'b1;
        wr_sel_n      = !wr_sel;
        wr_ptr_n      = '0;
        discard_n     = !pix.IN_LAST;
      end else begin
        st_n[wr_sel] = B_FILLING;
        wr_ptr_n     = wr_ptr + 1'b1;
      end
    end

    // Write only touches FREE/FILLING banks and read only FULL/READING ones, so no overlap.
    if (de_rise) begin
      if (bank_st[rd_sel] == B_FULL) st_n[rd_sel] = B_READING;
      else                           underflow_n  = 1'b1;
    end else if (de_fall && bank_st[rd_sel] == B_READING) begin
      st_n[rd_sel] = B_FREE;
      rd_sel_n     = !rd_sel;
    end

    if (DE_IN) rd_ptr_n = (&rd_ptr) ? rd_ptr : rd_ptr + 1'b1;
    else       rd_ptr_n = '0;

    if (vs_fall) begin
      st_n      = '{default: B_FREE};
      wr_sel_n  = 1'b0;
      rd_sel_n  = 1'b0;
      wr_ptr_n  = '0;
      rd_ptr_n  = '0;
      discard_n = (discard || bank_st[wr_sel] == B_FILLING || xfer) && !(xfer && pix.IN_LAST);
    end
  end

  always_ff @(posedge PixelClk) begin
    if (RST) begin
      bank_st   <= '{default: B_FREE};
      len       <= '{default: '0};
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      discard   <= 1'b0;
      de_q      <= 1'b0;
      vs_q      <= 1'b1;
      de_d1     <= 1'b0;
      hs_d1     <= 1'b1;
      vs_d1     <= 1'b1;
      pix_ok_q  <= 1'b0;
      LCD_DE    <= 1'b0;
      LCD_HSYNC <= 1'b1;
      LCD_VSYNC <= 1'b1;
      LCD_R     <= '0;
      LCD_G     <= '0;
      LCD_B     <= '0;
      UNDERFLOW <= 1'b0;
`ifdef LCD_LB_STATS_EN
      UNDERFLOW_CNT <= '0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      bank_st   <= st_n;
      len       <= len_n;
      wr_sel    <= wr_sel_n;
      rd_sel    <= rd_sel_n;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      discard   <= discard_n;
      de_q      <= DE_IN;
      vs_q      <= VS_IN;
      de_d1     <= DE_IN;
      hs_d1     <= HS_IN;
      vs_d1     <= VS_IN;
      pix_ok_q  <= pix_ok;
      LCD_DE    <= de_d1;
      LCD_HSYNC <= hs_d1;
      LCD_VSYNC <= vs_d1;
      {LCD_R, LCD_G, LCD_B} <= pix_ok_q ? rd_data : 16'h0000;
      UNDERFLOW <= underflow_n;
`ifdef LCD_LB_STATS_EN
      if (underflow_n && UNDERFLOW_CNT != 16'hFFFF) UNDERFLOW_CNT <= UNDERFLOW_CNT + 1'b1;
`endif
    end
  end

  // NOTE: the pixel RAM is not reset; bank length and state gate every read, so stale words never leak.
  always_ff @(posedge PixelClk) begin
    if (xfer && !discard) mem[{wr_sel, wr_ptr}] <= pix.IN_DATA;
    rd_data <= mem[{rd_sel, rd_ptr[ADDR_W-1:0]}];
  end

endmodule

// File: tb/tb_lcd_line_buffer.sv
// Directed bench for lcd_line_buffer: expected pixels queued per DE cycle, popped when LCD_DE shows them.
module tb_lcd_line_buffer;

  localparam int LINE = 800;

  logic        PixelClk;
  logic        RST;
  logic        DE_IN, HS_IN, VS_IN;
  logic        LCD_DE, LCD_HSYNC, LCD_VSYNC;
  logic [4:0]  LCD_R;
  logic [5:0]  LCD_G;
  logic [4:0]  LCD_B;
  logic        UNDERFLOW;
  logic [15:0] rgb;
`ifdef LCD_LB_STATS_EN
  logic [15:0] UNDERFLOW_CNT;
`endif

  lcd_line_buffer_if bus ();

  lcd_line_buffer #(.LINE_PIXELS(LINE), .ADDR_W(10)) dut (
    .PixelClk (PixelClk),
    .RST      (RST),
    .pix      (bus.slave),
    .DE_IN    (DE_IN),
    .HS_IN    (HS_IN),
    .VS_IN    (VS_IN),
    .LCD_DE   (LCD_DE),
    .LCD_HSYNC(LCD_HSYNC),
    .LCD_VSYNC(LCD_VSYNC),
    .LCD_R    (LCD_R),
    .LCD_G    (LCD_G),
    .LCD_B    (LCD_B),
    .UNDERFLOW(UNDERFLOW)
`ifdef LCD_LB_STATS_EN
    ,
    .UNDERFLOW_CNT(UNDERFLOW_CNT)
`endif
  );

  assign rgb = {LCD_R, LCD_G, LCD_B};

  initial begin
    PixelClk = 1'b0;
    forever #5 PixelClk = !PixelClk;
  end

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  int          uf_seen = 0;
  int          uf_exp = 0;
  int          uf_since_rst = 0;
  int          ready_hits = 0;
  int          since_rst = 0;
  int          cyc;
  logic        de_h1 = 1'b0, de_h2 = 1'b0;
  logic        hs_h1 = 1'b1, hs_h2 = 1'b1;
  logic        vs_h1 = 1'b1, vs_h2 = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PixelClk);
    #1;
  endtask

  // Reference sync/DE history: what the outputs must show two edges later.
  always @(posedge PixelClk) begin
    de_h1 <= DE_IN;  de_h2 <= de_h1;
    hs_h1 <= HS_IN;  hs_h2 <= hs_h1;
    vs_h1 <= VS_IN;  vs_h2 <= vs_h1;
    since_rst <= RST ? 0 : ((since_rst < 10) ? since_rst + 1 : since_rst);
  end

  always @(negedge PixelClk) begin
    if (UNDERFLOW === 1'b1) uf_seen++;
    if (since_rst >= 2) begin
      check("lcd_de_delay", LCD_DE, de_h2);
      check("hsync_delay", LCD_HSYNC, hs_h2);
      check("vsync_delay", LCD_VSYNC, vs_h2);
      if (LCD_DE === 1'b1) begin
        if (exp_q.size() == 0) check("pixel_unexpected_de", LCD_DE, 0);
        else                   check("pixel", rgb, exp_q.pop_front());
      end else begin
        check("blank_rgb", rgb, 0);
      end
    end
  end

  task automatic send_line(input int n, input int base, input bit last, output int cycles);
    bit ok;
    int w;
    cycles = 0;
    for (int i = 0; i < n; i++) begin
      bus.IN_VALID = 1'b1;
      bus.IN_DATA  = 16'(base + i);
      bus.IN_LAST  = last && (i == n - 1);
      ok = 1'b0;
      w  = 0;
      while (!ok && w < 5000) begin
        @(negedge PixelClk);
        ok = bus.IN_READY;
        tick();
        w++;
      end
      cycles += w;
      if (!ok) begin
        check("in_ready_wait", ok, 1);
        break;
      end
    end
    bus.IN_VALID = 1'b0;
    bus.IN_LAST  = 1'b0;
  endtask

  task automatic de_window(input int n_valid, input int base, input bit watch);
    for (int i = 0; i < LINE; i++) begin
      exp_q.push_back((i < n_valid) ? 16'(base + i) : 16'h0000);
      DE_IN = 1'b1;
      if (watch) begin
        @(negedge PixelClk);
        if (bus.IN_READY === 1'b1) ready_hits++;
      end
      tick();
    end
    DE_IN = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      HS_IN = !(i >= 2 && i < 6);
      tick();
    end
    HS_IN = 1'b1;
  endtask

  task automatic end_window(input string tag);
    idle(12);
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_underflow"}, uf_seen, uf_exp);
  endtask

  initial begin
    RST = 1'b1;
    DE_IN = 1'b0;
    HS_IN = 1'b1;
    VS_IN = 1'b1;
    bus.IN_VALID = 1'b0;
    bus.IN_DATA  = '0;
    bus.IN_LAST  = 1'b0;
    repeat (3) tick();

    @(negedge PixelClk);
    check("rst_in_ready", bus.IN_READY, 0);
    check("rst_lcd_de", LCD_DE, 0);
    check("rst_hsync", LCD_HSYNC, 1);
    check("rst_vsync", LCD_VSYNC, 1);
    check("rst_rgb", rgb, 0);
    check("rst_underflow", UNDERFLOW, 0);
`ifdef LCD_LB_STATS_EN
    check("rst_uf_cnt", UNDERFLOW_CNT, 0);
`endif
    tick();
    RST = 1'b0;
    @(negedge PixelClk);
    check("ready_after_rst", bus.IN_READY, 1);
    tick();
    idle(4);

    // Full line, value = index, into bank 0.
    send_line(LINE, 0, 1'b1, cyc);
    de_window(LINE, 0, 1'b0);
    end_window("full_line");

    // Starved window: black line, underflow pulse, read bank unchanged.
    de_window(0, 0, 1'b0);
    uf_exp++;
    uf_since_rst++;
    end_window("starved");

    // Short line into bank 1; pixels past 500 must be black.
    send_line(500, 16'h1000, 1'b1, cyc);
    de_window(500, 16'h1000, 1'b0);
    end_window("short_500");

    // Overlong line: 900 pixels, last 100 dropped, producer never stalled.
    send_line(900, 16'h2000, 1'b1, cyc);
    check("overlong_ready_held", cyc, 900);
    de_window(LINE, 16'h2000, 1'b0);
    end_window("overlong");

    // Short line over stale bank-1 data from the 500-pixel line.
    send_line(300, 16'hB000, 1'b1, cyc);
    de_window(300, 16'hB000, 1'b0);
    end_window("short_stale");

    // Both banks full: producer blocked until the first DE falling edge frees bank 0.
    send_line(LINE, 16'h3000, 1'b1, cyc);
    send_line(LINE, 16'h4000, 1'b1, cyc);
    @(negedge PixelClk);
    check("ready_both_full", bus.IN_READY, 0);
    tick();
    ready_hits = 0;
    de_window(LINE, 16'h3000, 1'b1);
    check("ready_during_read", ready_hits, 0);
    @(negedge PixelClk);
    check("ready_at_de_fall", bus.IN_READY, 0);
    tick();
    @(negedge PixelClk);
    check("ready_after_free", bus.IN_READY, 1);
    tick();
    send_line(200, 16'h5000, 1'b1, cyc);
    end_window("both_full_a");
    de_window(LINE, 16'h4000, 1'b0);
    end_window("both_full_b");
    de_window(200, 16'h5000, 1'b0);
    end_window("refill_c");

    // Frame resync mid-fill: in-flight line discarded, following line lands in bank 0.
    send_line(100, 16'h6000, 1'b0, cyc);
    idle(2);
    VS_IN = 1'b0;
    repeat (3) tick();
    VS_IN = 1'b1;
    send_line(50, 16'h7000, 1'b1, cyc);
    idle(4);
    de_window(0, 0, 1'b0);
    uf_exp++;
    uf_since_rst++;
    end_window("vs_discard");
    send_line(LINE, 16'h8000, 1'b1, cyc);
    de_window(LINE, 16'h8000, 1'b0);
    end_window("vs_next_line");

    for (int k = 0; k < 2; k++) begin
      de_window(0, 0, 1'b0);
      uf_exp++;
      uf_since_rst++;
      end_window("starved_run");
    end
`ifdef LCD_LB_STATS_EN
    check("uf_cnt_total", UNDERFLOW_CNT, uf_since_rst);
`endif

    // Reset mid-line: partial line must not survive.
    send_line(400, 16'hA000, 1'b0, cyc);
    RST = 1'b1;
    tick();
    tick();
    @(negedge PixelClk);
    check("ready_in_midline_rst", bus.IN_READY, 0);
    tick();
    RST = 1'b0;
    uf_since_rst = 0;
    @(negedge PixelClk);
    check("ready_after_midline_rst", bus.IN_READY, 1);
`ifdef LCD_LB_STATS_EN
    check("uf_cnt_cleared", UNDERFLOW_CNT, 0);
`endif
    tick();
    idle(4);
    de_window(0, 0, 1'b0);
    uf_exp++;
    uf_since_rst++;
    end_window("rst_no_partial");
`ifdef LCD_LB_STATS_EN
    check("uf_cnt_after_rst", UNDERFLOW_CNT, uf_since_rst);
`endif
    send_line(LINE, 16'h9000, 1'b1, cyc);
    de_window(LINE, 16'h9000, 1'b0);
    end_window("post_rst_line");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
